burst_ram_arbiter: RTL and testbench

Two-port arbiter that lets the instruction cache (port 0) and the data cache (port 1) share the single BurstRAM command/data port. It captures each cache's one-cycle command pulse into a per-port pending slot and dispatches one burst at a time to BurstRAM. Ports are served round-robin. Read beats are routed only to the owning port, and write beats are forwarded from the owning port.

---
 rtl/burst_ram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter that shares one BurstRAM command/data port between the
// instruction cache (port 0) and the data cache (port 1), one burst at a time.
module burst_ram_arbiter #(
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 8,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
    parameter int unsigned RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 m0_cmd,
    input  logic                                 m0_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m0_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m0_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m0_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   m0_rd_data,
    output logic                                 m0_rd_data_valid,
    output logic                                 m0_busy,
    output logic                                 m0_grant,

    input  logic                                 m1_cmd,
    input  logic                                 m1_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m1_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_rd_data,
    output logic                                 m1_rd_data_valid,
    output logic                                 m1_busy,
    output logic                                 m1_grant,

    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int unsigned CntW = $clog2(RAM_BURST_DATA_COUNT);
    localparam logic [CntW-1:0] LastBeat = CntW'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e                                 state_q, state_d;
    logic [1:0]                             slot_valid_q, slot_valid_d;
    logic [1:0]                             slot_cmd_q, slot_cmd_d;
    logic [1:0][RAM_DEPTH_BITWIDTH-1:0]     slot_addr_q, slot_addr_d;
    logic [1:0]                             busy_q, busy_d;
    logic [1:0]                             grant_q, grant_d;
    logic                                   owner_q, owner_d;
    logic                                   last_q, last_d;
    logic [CntW-1:0]                        cnt_q, cnt_d;
    logic                                   br_cmd_q, br_cmd_d;
    logic                                   br_cmd_en_q, br_cmd_en_d;
    logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr_q, br_addr_d;

    logic [1:0]                             req_en, req_cmd;
    logic [1:0][RAM_DEPTH_BITWIDTH-1:0]     req_addr;
    logic                                   pick;

    assign req_en   = {m1_cmd_en, m0_cmd_en};
    assign req_cmd  = {m1_cmd, m0_cmd};
    assign req_addr = {m1_addr, m0_addr};

    // With both slots pending, the port not served last wins.
    assign pick = (&slot_valid_q) ? ~last_q : slot_valid_q[1];

    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_cmd_d   = slot_cmd_q;
        slot_addr_d  = slot_addr_q;
        busy_d       = busy_q;
        grant_d      = '0;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        br_cmd_d     = br_cmd_q;
        br_cmd_en_d  = 1'b0;
        br_addr_d    = br_addr_q;

        for (int p = 0; p < 2; p++) begin
            if (req_en[p] && !busy_q[p]) begin
                slot_valid_d[p] = 1'b1;
                slot_cmd_d[p]   = req_cmd[p];
                slot_addr_d[p]  = req_addr[p];
                busy_d[p]       = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (!br_busy && (|slot_valid_q)) begin
                    owner_d            = pick;
                    last_d             = pick;
                    cnt_d              = '0;
                    br_cmd_en_d        = 1'b1;
                    br_cmd_d           = slot_cmd_q[pick];
                    br_addr_d          = slot_addr_q[pick];
                    grant_d[pick]      = 1'b1;
                    slot_valid_d[pick] = 1'b0;
                    state_d            = slot_cmd_q[pick] ? StWrite : StRead;
                end
            end
            StRead: begin
                if (br_rd_data_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBeat) begin
                        state_d         = StIdle;
                        busy_d[owner_q] = 1'b0;
                    end
                end
            end
            StWrite: begin
                // One beat per cycle, starting in the grant cycle.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBeat) begin
                    state_d         = StIdle;
                    busy_d[owner_q] = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            slot_valid_q <= '0;
            slot_cmd_q   <= '0;
            slot_addr_q  <= '0;
            busy_q       <= '0;
            grant_q      <= '0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            br_cmd_q     <= 1'b0;
            br_cmd_en_q  <= 1'b0;
            br_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_cmd_q   <= slot_cmd_d;
            slot_addr_q  <= slot_addr_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            br_cmd_q     <= br_cmd_d;
            br_cmd_en_q  <= br_cmd_en_d;
            br_addr_q    <= br_addr_d;
        end
    end

    assign m0_rd_data       = br_rd_data;
    assign m1_rd_data       = br_rd_data;
    assign m0_rd_data_valid = (state_q == StRead) && !owner_q && br_rd_data_valid;
    assign m1_rd_data_valid = (state_q == StRead) && owner_q && br_rd_data_valid;
    assign m0_busy          = busy_q[0];
    assign m1_busy          = busy_q[1];
    assign m0_grant         = grant_q[0];
    assign m1_grant         = grant_q[1];

    assign br_cmd       = br_cmd_q;
    assign br_cmd_en    = br_cmd_en_q;
    assign br_addr      = br_addr_q;
    assign br_wr_data   = (state_q == StWrite) ? (owner_q ? m1_wr_data : m0_wr_data) : '0;
    assign br_data_mask = (state_q == StWrite) ? (owner_q ? m1_data_mask : m0_data_mask) : '0;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: directed table, hand-written corner sequences and
// random traffic checked every cycle against a transaction-level model.
module tb_burst_ram_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 64;
    localparam int MW  = DW / 8;
    localparam int CNT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cmd, m0_cmd_en, m1_cmd, m1_cmd_en;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
    logic [MW-1:0] m0_data_mask, m1_data_mask;
    logic          m0_rd_data_valid, m0_busy, m0_grant;
    logic          m1_rd_data_valid, m1_busy, m1_grant;
    logic          br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data, br_rd_data;
    logic [MW-1:0] br_data_mask;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH      (AW),
        .RAM_BURST_DATA_BITWIDTH (DW),
        .RAM_BURST_DATA_COUNT    (CNT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .m0_cmd           (m0_cmd),
        .m0_cmd_en        (m0_cmd_en),
        .m0_addr          (m0_addr),
        .m0_wr_data       (m0_wr_data),
        .m0_data_mask     (m0_data_mask),
        .m0_rd_data       (m0_rd_data),
        .m0_rd_data_valid (m0_rd_data_valid),
        .m0_busy          (m0_busy),
        .m0_grant         (m0_grant),
        .m1_cmd           (m1_cmd),
        .m1_cmd_en        (m1_cmd_en),
        .m1_addr          (m1_addr),
        .m1_wr_data       (m1_wr_data),
        .m1_data_mask     (m1_data_mask),
        .m1_rd_data       (m1_rd_data),
        .m1_rd_data_valid (m1_rd_data_valid),
        .m1_busy          (m1_busy),
        .m1_grant         (m1_grant),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    // Reference model: pending requests, the burst in flight and beats left.
    bit [1:0]      mb, mp, mpc, mgnt;
    logic [AW-1:0] mpa [2];
    bit            mact, mown, mwr, mlast, mcen, mcmd;
    logic [AW-1:0] maddr;
    int            mleft;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_check();
        bit [1:0]      eb, eg;
        bit            ecen, ecmd, erv0, erv1, chk_cmd;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewr;
        logic [MW-1:0] emask;
        if (!rst) begin
            eb = '0; eg = '0; ecen = 0; ecmd = 0; erv0 = 0; erv1 = 0;
            eaddr = '0; ewr = '0; emask = '0; chk_cmd = 1;
        end else begin
            eb = mb; eg = mgnt; ecen = mcen; ecmd = mcmd; eaddr = maddr; chk_cmd = mcen;
            erv0 = mact && !mwr && !mown && br_rd_data_valid;
            erv1 = mact && !mwr && mown && br_rd_data_valid;
            ewr   = (mact && mwr) ? (mown ? m1_wr_data : m0_wr_data) : '0;
            emask = (mact && mwr) ? (mown ? m1_data_mask : m0_data_mask) : '0;
        end
        check("model m0_busy", m0_busy, eb[0]);
        check("model m1_busy", m1_busy, eb[1]);
        check("model m0_grant", m0_grant, eg[0]);
        check("model m1_grant", m1_grant, eg[1]);
        check("model br_cmd_en", br_cmd_en, ecen);
        if (chk_cmd) begin
            check("model br_cmd", br_cmd, ecmd);
            check("model br_addr", br_addr, eaddr);
        end
        check("model m0_rd_data_valid", m0_rd_data_valid, erv0);
        check("model m1_rd_data_valid", m1_rd_data_valid, erv1);
        check("model br_wr_data", br_wr_data, ewr);
        check("model br_data_mask", br_data_mask, emask);
        check("model m0_rd_data", m0_rd_data, br_rd_data);
        check("model m1_rd_data", m1_rd_data, br_rd_data);
    endtask

    task automatic model_step();
        bit cap0, cap1, w;
        if (!rst) begin
            mb = '0; mp = '0; mpc = '0; mgnt = '0;
            mact = 0; mown = 0; mwr = 0; mlast = 1; mcen = 0; mcmd = 0;
            maddr = '0; mleft = 0;
        end else begin
            cap0 = m0_cmd_en && !mb[0];
            cap1 = m1_cmd_en && !mb[1];
            mgnt = '0;
            mcen = 0;
            if (mact) begin
                if (mwr || br_rd_data_valid) mleft--;
                if (mleft == 0) begin
                    mact     = 0;
                    mb[mown] = 0;
                end
            end else if (!br_busy && (mp != 2'b00)) begin
                w       = (mp == 2'b11) ? !mlast : mp[1];
                mact    = 1;
                mown    = w;
                mwr     = mpc[w];
                mleft   = CNT;
                mlast   = w;
                mp[w]   = 0;
                mgnt[w] = 1;
                mcen    = 1;
                mcmd    = mpc[w];
                maddr   = mpa[w];
            end
            if (cap0) begin mp[0] = 1; mpc[0] = m0_cmd; mpa[0] = m0_addr; mb[0] = 1; end
            if (cap1) begin mp[1] = 1; mpc[1] = m1_cmd; mpa[1] = m1_addr; mb[1] = 1; end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
        m0_cmd_en = 1'b0;
        m1_cmd_en = 1'b0;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic feed_beats(input logic [DW-1:0] base);
        for (int i = 0; i < CNT; i++) begin
            br_rd_data_valid = 1'b1;
            br_rd_data       = base + DW'(i);
            step();
        end
        br_rd_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m0_cmd_en = 1'b0; m1_cmd_en = 1'b0; m0_cmd = 1'b0; m1_cmd = 1'b0;
        br_busy = 1'b0; br_rd_data_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        bit            ce0;
        logic [AW-1:0] a0;
        bit            rv;
        logic [DW-1:0] rd;
        bit            busy0;
        bit            gnt0;
        bit            cen;
        logic [AW-1:0] addr;
        bit            rv0;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n_issued;
        logic [AW-1:0] addr_seen;

        m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
        m0_data_mask = '0; m1_data_mask = '0; br_rd_data = '0;
        do_reset();

        // Single read from port 0, beats A..D with one idle gap.
        tbl[0] = '{1'b1, 8'h10, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 64'hA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 64'hB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 64'hD, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 9; i++) begin
            m0_cmd_en        = tbl[i].ce0;
            m0_cmd           = 1'b0;
            m0_addr          = tbl[i].a0;
            br_rd_data_valid = tbl[i].rv;
            br_rd_data       = tbl[i].rd;
            sample();
            check($sformatf("tbl[%0d] m0_busy", i), m0_busy, tbl[i].busy0);
            check($sformatf("tbl[%0d] m0_grant", i), m0_grant, tbl[i].gnt0);
            check($sformatf("tbl[%0d] br_cmd_en", i), br_cmd_en, tbl[i].cen);
            if (tbl[i].cen) check($sformatf("tbl[%0d] br_addr", i), br_addr, tbl[i].addr);
            check($sformatf("tbl[%0d] m0_rd_data_valid", i), m0_rd_data_valid, tbl[i].rv0);
            check($sformatf("tbl[%0d] m1_rd_data_valid", i), m1_rd_data_valid, 1'b0);
            if (tbl[i].rv) check($sformatf("tbl[%0d] m0_rd_data", i), m0_rd_data, tbl[i].rd);
            advance();
        end
        br_rd_data_valid = 1'b0;

        // Simultaneous reads after reset: port 0 first, port 1 two cycles after its last beat.
        do_reset();
        m0_cmd_en = 1'b1; m0_addr = 8'h20; m1_cmd_en = 1'b1; m1_addr = 8'h40;
        step();
        step();
        sample();
        check("sim p0 grant", m0_grant, 1'b1);
        check("sim p1 no grant", m1_grant, 1'b0);
        check("sim p0 addr", br_addr, 8'h20);
        advance();
        feed_beats(64'h100);
        sample();
        check("sim p1 not yet", br_cmd_en, 1'b0);
        check("sim p0 busy clear", m0_busy, 1'b0);
        advance();
        sample();
        check("sim p1 grant", m1_grant, 1'b1);
        check("sim p1 addr", br_addr, 8'h40);
        advance();
        feed_beats(64'h200);
        step();

        // Port 0 served alone, then both pend under br_busy: port 1 must win.
        m0_cmd_en = 1'b1; m0_addr = 8'h21;
        step();
        step();
        step();
        feed_beats(64'h300);
        step();
        br_busy = 1'b1;
        m0_cmd_en = 1'b1; m0_addr = 8'h22; m1_cmd_en = 1'b1; m1_addr = 8'h41;
        step();
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rr held by br_busy", br_cmd_en, 1'b0);
            advance();
        end
        br_busy = 1'b0;
        step();
        sample();
        check("rr p1 wins", m1_grant, 1'b1);
        check("rr p0 waits", m0_grant, 1'b0);
        check("rr p1 addr", br_addr, 8'h41);
        advance();
        feed_beats(64'h400);
        step();
        step();
        feed_beats(64'h500);
        step();

        // Port 1 write: wr_data = beat index from the grant cycle on.
        do_reset();
        m1_cmd = 1'b1; m1_cmd_en = 1'b1; m1_addr = 8'h08;
        step();
        step();
        for (int i = 0; i < CNT; i++) begin
            m1_wr_data   = DW'(i);
            m1_data_mask = 8'hFF;
            sample();
            if (i == 0) begin
                check("wr grant", m1_grant, 1'b1);
                check("wr br_cmd", br_cmd, 1'b1);
                check("wr br_addr", br_addr, 8'h08);
            end
            check($sformatf("wr beat %0d data", i), br_wr_data, DW'(i));
            check($sformatf("wr beat %0d mask", i), br_data_mask, 8'hFF);
            check($sformatf("wr beat %0d busy", i), m1_busy, 1'b1);
            advance();
        end
        sample();
        check("wr busy clear", m1_busy, 1'b0);
        check("wr data idle", br_wr_data, 64'h0);
        advance();
        m1_cmd = 1'b0;

        // Back-pressure with a dropped second command.
        do_reset();
        br_busy = 1'b1;
        m0_cmd = 1'b0; m0_addr = 8'h33; m0_cmd_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                m0_cmd_en = 1'b1; m0_addr = 8'h55; m0_cmd = 1'b1;
            end
            sample();
            check("bp no dispatch", br_cmd_en, 1'b0);
            advance();
        end
        br_busy = 1'b0; m0_cmd = 1'b0;
        n_issued = 0; addr_seen = '0;
        br_rd_data_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (br_cmd_en) begin
                n_issued++;
                addr_seen = br_addr;
            end
            advance();
        end
        br_rd_data_valid = 1'b0;
        check("bp one burst", n_issued, 1);
        check("bp addr", addr_seen, 8'h33);
        sample();
        check("bp busy clear", m0_busy, 1'b0);
        advance();

        // Reset after beat 2 of a port 0 read; RAM keeps delivering.
        do_reset();
        m0_cmd_en = 1'b1; m0_addr = 8'h60;
        step();
        step();
        step();
        br_rd_data_valid = 1'b1;
        step();
        step();
        rst = 1'b0;
        sample();
        check("rst mid rv0", m0_rd_data_valid, 1'b0);
        check("rst mid busy0", m0_busy, 1'b0);
        check("rst mid cmd_en", br_cmd_en, 1'b0);
        advance();
        rst = 1'b1;
        sample();
        check("rst after rv0", m0_rd_data_valid, 1'b0);
        check("rst after rv1", m1_rd_data_valid, 1'b0);
        advance();
        br_rd_data_valid = 1'b0;
        m1_cmd_en = 1'b1; m1_addr = 8'h70;
        step();
        step();
        sample();
        check("post rst p1 grant", m1_grant, 1'b1);
        check("post rst p1 addr", br_addr, 8'h70);
        advance();
        feed_beats(64'h600);
        step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst              = ($urandom_range(399) == 0) ? 1'b0 : 1'b1;
            m0_cmd_en        = ($urandom_range(3) == 0);
            m0_cmd           = 1'($urandom_range(1));
            m0_addr          = AW'($urandom);
            m0_wr_data       = {$urandom, $urandom};
            m0_data_mask     = MW'($urandom);
            m1_cmd_en        = ($urandom_range(3) == 0);
            m1_cmd           = 1'($urandom_range(1));
            m1_addr          = AW'($urandom);
            m1_wr_data       = {$urandom, $urandom};
            m1_data_mask     = MW'($urandom);
            br_busy          = ($urandom_range(3) == 0);
            br_rd_data_valid = 1'($urandom_range(1));
            br_rd_data       = {$urandom, $urandom};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
